// File: rtl/divider_unsigned_iter.sv
// -----------------------------------------------------------------------------
// divider_unsigned_iter
//   Multi-cycle 32-bit integer divider. It uses restoring division and produces
//   one quotient bit per clock. Signed requests are divided on their magnitudes
//   and the signs are fixed up on the final iteration. The divider serves
//   DIV/DIVU/REM/REMU in the execute stage. Valid/ready handshakes on both sides
//   let the pipeline stall on it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   request valid
//   in_ready   divider can accept a request (high only in IDLE)
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   dividend   numerator
//   divisor    denominator
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts the result
//   quotient   result quotient
//   remainder  result remainder
//
// Also contains cla, the 32-bit carry-lookahead adder used for the trial
// subtraction.
// -----------------------------------------------------------------------------

module cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;

  assign w_g    = a & b;
  assign w_p    = a ^ b;
  assign w_c[0] = cin;

  // 4-bit lookahead groups, rippled group to group. The carry out of the top
  // bit is not an output, so the last group stops at bit 31.
  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = 4 * gi;
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_c[B]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    if (gi < 7) begin : g_cout
      assign w_c[B+4] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    end
  end

  assign sum = w_p ^ w_c;
endmodule

module divider_unsigned_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  if (WIDTH != 32) begin : g_bad_width
    $error("divider_unsigned_iter: WIDTH must be 32 to match cla");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dq;     // working dividend; quotient bits shift in at the LSB
  logic [WIDTH-1:0] r_dvs;    // divisor magnitude
  logic [WIDTH-1:0] r_rem;    // partial remainder
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic [4:0]       r_count;
  logic             r_signed;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dvz;    // divisor was zero; result is already loaded
  logic             r_in_ready;
  logic             r_out_valid;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic             w_dd_neg;
  logic             w_dv_neg;
  logic [WIDTH-1:0] w_abs_dd;
  logic [WIDTH-1:0] w_abs_dv;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_dvs_n;
  logic [WIDTH-1:0] w_diff;
  logic             w_hi;
  logic             w_c32;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_dd_neg = is_signed & dividend[WIDTH-1];
  assign w_dv_neg = is_signed & divisor[WIDTH-1];
  assign w_abs_dd = w_dd_neg ? neg2c(dividend) : dividend;
  assign w_abs_dv = w_dv_neg ? neg2c(divisor) : divisor;

  assign w_shifted = {r_rem[WIDTH-2:0], r_dq[WIDTH-1]};
  assign w_hi      = r_rem[WIDTH-1];
  assign w_dvs_n   = ~r_dvs;

  cla u_cla (
    .a   (w_shifted),
    .b   (w_dvs_n),
    .cin (1'b1),
    .sum (w_diff)
  );

  // Carry out of the top bit, rebuilt from the MSB operands and the MSB of the
  // sum. A carry means shifted >= divisor. hi covers the 33rd bit of the
  // shifted remainder.
  assign w_c32 = (w_shifted[WIDTH-1] & ~r_dvs[WIDTH-1])
               | ((w_shifted[WIDTH-1] ^ ~r_dvs[WIDTH-1]) & ~w_diff[WIDTH-1]);
  assign w_ge      = w_hi | w_c32;
  assign w_rem_nxt = w_ge ? w_diff : w_shifted;
  assign w_q_nxt   = {r_dq[WIDTH-2:0], w_ge};

  assign w_q_fix = (r_signed & r_neg_q) ? neg2c(w_q_nxt) : w_q_nxt;
  assign w_r_fix = (r_signed & r_neg_r) ? neg2c(w_rem_nxt) : w_rem_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dq        <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_remo      <= '0;
      r_count     <= '0;
      r_signed    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dvz       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_signed   <= is_signed;
            r_neg_q    <= w_dd_neg ^ w_dv_neg;
            r_neg_r    <= w_dd_neg;
            r_dq       <= w_abs_dd;
            r_dvs      <= w_abs_dv;
            r_rem      <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
            // A zero divisor loads its fixed result now and spends a single
            // cycle in BUSY, so out_valid rises one edge after the accept.
            r_dvz      <= (divisor == '0);
            if (divisor == '0) begin
              r_quot <= '1;
              r_remo <= dividend;
            end
          end
        end
        BUSY: begin
          if (r_dvz) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_rem   <= w_rem_nxt;
            r_dq    <= w_q_nxt;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) begin
              r_quot      <= w_q_fix;
              r_remo      <= w_r_fix;
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_remo;
endmodule

// File: tb/tb_divider_unsigned_iter.sv
module tb_divider_unsigned_iter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_checks = 0;
  int n_errors = 0;

  divider_unsigned_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands, including the two corner cases.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] eq;
    logic [31:0] er;
    logic [31:0] hq;
    logic [31:0] hr;
    int          n;
    logic        busy_ok;
    logic        stable;
    int          exp_lat;
    ref_div(s, a, b, eq, er);
    exp_lat = (b == 32'd0) ? 1 : 32;
    @(negedge clk);
    check_eq({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Operand changes after the accept must have no effect.
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    n = 0;
    busy_ok = 1'b1;
    do begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 40);
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_in_ready_busy"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, "_quotient"}, quotient, eq);
    check_eq({tag, "_remainder"}, remainder, er);
    hq = quotient;
    hr = remainder;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (quotient !== hq || remainder !== hr || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    check_eq({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_out_valid_clr"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    rst_n = 1'b0; in_valid = 1'b0; is_signed = 1'b0;
    dividend = 32'd0; divisor = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_quotient", quotient, 32'd0);
    check_eq("rst_remainder", remainder, 32'd0);
    rst_n = 1'b1;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 0);
    run_op("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 1);
    run_op("s100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 0);
    run_op("u_div0", 1'b0, 32'h1234_5678, 32'd0, 0);
    run_op("s_div0", 1'b1, 32'h1234_5678, 32'd0, 2);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("u_hi", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op("u_backpr", 1'b0, 32'hDEAD_BEEF, 32'd13, 10);

    // Reset in the middle of an operation.
    @(negedge clk);
    in_valid = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    run_op("after_rst_9_3", 1'b0, 32'd9, 32'd3, 0);

    for (int k = 0; k < 40; k++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(1, 20));
        1:       rb = 32'd0;
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      run_op("rand", rs, ra, rb, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
